// File: rtl/decode_execute_stage_if.sv
// Bundle of signals exchanged between the decode side and the ID/EX register.
//   master : decode/hazard-control side; drives ID fields, RF read data,
//            writeback echo and stall/flush controls; observes the EX outputs
//   slave  : the ID/EX register itself
// Register index width is AWL-1, shared with the register file.
interface decode_execute_stage_if #(
    parameter int AWL = 6,
    parameter int DWL = 32,
    parameter int CWL = 16,
    parameter int PCW = 16
);
    localparam int RW = AWL - 1;

    logic           stall_e;
    logic           flush_e;
    logic           id_valid;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic [RW-1:0]  id_rd;
    logic [DWL-1:0] rf_rd1;
    logic [DWL-1:0] rf_rd2;
    logic [DWL-1:0] id_imm;
    logic [CWL-1:0] id_ctrl;
    logic           wb_we;
    logic [RW-1:0]  wb_wa;
    logic [DWL-1:0] wb_wd;

    logic           stall_d;
    logic           ex_valid;
    logic [RW-1:0]  ex_rs;
    logic [RW-1:0]  ex_rt;
    logic [RW-1:0]  ex_rd;
    logic [DWL-1:0] ex_a;
    logic [DWL-1:0] ex_b;
    logic [DWL-1:0] ex_imm;
    logic [CWL-1:0] ex_ctrl;
    logic [PCW-1:0] bubbles;

    modport master (
        output stall_e, flush_e, id_valid, id_rs, id_rt, id_rd,
               rf_rd1, rf_rd2, id_imm, id_ctrl, wb_we, wb_wa, wb_wd,
        input  stall_d, ex_valid, ex_rs, ex_rt, ex_rd,
               ex_a, ex_b, ex_imm, ex_ctrl, bubbles
    );

    modport slave (
        input  stall_e, flush_e, id_valid, id_rs, id_rt, id_rd,
               rf_rd1, rf_rd2, id_imm, id_ctrl, wb_we, wb_wa, wb_wd,
        output stall_d, ex_valid, ex_rs, ex_rt, ex_rd,
               ex_a, ex_b, ex_imm, ex_ctrl, bubbles
    );
endinterface

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register.
// Registers the decoded instruction and its two register-file operands for
// the execute stage, with flush, stall (holding operands coherent with
// writeback) and load-use bubble insertion. Counts bubbles, saturating.
// Ports:
//   clk  : clock, all state changes on rising edge
//   rst  : asynchronous active-high reset
//   bus  : decode_execute_stage_if.slave (ID fields, RF read data, writeback
//          echo, stall/flush controls in; stall_d and EX register contents out)
module decode_execute_stage #(
    parameter int AWL   = 6,
    parameter int DWL   = 32,
    parameter int CWL   = 16,
    parameter int LDBIT = 0,
    parameter int PCW   = 16
) (
    input logic                  clk,
    input logic                  rst,
    decode_execute_stage_if.slave bus
);
    localparam int RW = AWL - 1;

    logic           ex_valid;
    logic [RW-1:0]  ex_rs;
    logic [RW-1:0]  ex_rt;
    logic [RW-1:0]  ex_rd;
    logic [DWL-1:0] ex_a;
    logic [DWL-1:0] ex_b;
    logic [DWL-1:0] ex_imm;
    logic [CWL-1:0] ex_ctrl;
    logic [PCW-1:0] bubbles;
    logic           stall_d;
    logic           wb_hit;

    // Load-use hazard: the load in EX writes a register the decode-stage
    // instruction reads. A flush kills the load, so no hazard then.
    assign stall_d = bus.id_valid & ex_valid & ex_ctrl[LDBIT]
                   & (ex_rt != '0)
                   & ((ex_rt == bus.id_rs) | (ex_rt == bus.id_rt))
                   & ~bus.flush_e;

    // A qualifying writeback while held; register 0 is never refreshed.
    assign wb_hit = ex_valid & bus.wb_we & (bus.wb_wa != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
            bubbles  <= '0;
        end else if (bus.flush_e) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
        end else if (bus.stall_e) begin
            // Held operands would go stale if their source register is
            // written while we wait, so pick up the writeback value.
            if (wb_hit && (bus.wb_wa == ex_rs)) begin
                ex_a <= bus.wb_wd;
            end
            if (wb_hit && (bus.wb_wa == ex_rt)) begin
                ex_b <= bus.wb_wd;
            end
        end else if (stall_d) begin
            ex_valid <= 1'b0;
            ex_rs    <= '0;
            ex_rt    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_ctrl  <= '0;
            if (bubbles != '1) begin
                bubbles <= bubbles + {{(PCW-1){1'b0}}, 1'b1};
            end
        end else begin
            // The RF writes on the falling edge, so RFRD already reflects
            // this cycle's writeback; only register 0 needs forcing.
            ex_valid <= bus.id_valid;
            ex_rs    <= bus.id_rs;
            ex_rt    <= bus.id_rt;
            ex_rd    <= bus.id_rd;
            ex_a     <= (bus.id_rs == '0) ? '0 : bus.rf_rd1;
            ex_b     <= (bus.id_rt == '0) ? '0 : bus.rf_rd2;
            ex_imm   <= bus.id_imm;
            ex_ctrl  <= bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    assign bus.stall_d  = stall_d;
    assign bus.ex_valid = ex_valid;
    assign bus.ex_rs    = ex_rs;
    assign bus.ex_rt    = ex_rt;
    assign bus.ex_rd    = ex_rd;
    assign bus.ex_a     = ex_a;
    assign bus.ex_b     = ex_b;
    assign bus.ex_imm   = ex_imm;
    assign bus.ex_ctrl  = ex_ctrl;
    assign bus.bubbles  = bubbles;
endmodule

// File: tb/tb_decode_execute_stage.sv
// Testbench for decode_execute_stage: directed vectors, a behavioural model
// of the EX register checked every falling edge, and literal expectations.
module tb_decode_execute_stage;
    localparam int AWL = 6;
    localparam int DWL = 32;
    localparam int CWL = 16;
    localparam int PCW = 4;
    localparam int RW  = AWL - 1;
    localparam int BUB_MAX = (1 << PCW) - 1;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   started = 1'b0;

    decode_execute_stage_if #(.AWL(AWL), .DWL(DWL), .CWL(CWL), .PCW(PCW)) dif ();

    decode_execute_stage #(
        .AWL(AWL), .DWL(DWL), .CWL(CWL), .LDBIT(0), .PCW(PCW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             valid;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  rd;
        logic [DWL-1:0] a;
        logic [DWL-1:0] b;
        logic [DWL-1:0] imm;
        logic [CWL-1:0] ctrl;
    } ex_t;

    ex_t m;
    int  m_bub;

    function bit model_hazard();
        return dif.id_valid && m.valid && m.ctrl[0] && (m.rt != 0)
            && ((m.rt == dif.id_rs) || (m.rt == dif.id_rt)) && !dif.flush_e;
    endfunction

    // Model of the EX contents: what the instruction in EX must look like.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '{default: '0};
            m_bub = 0;
        end else if (dif.flush_e) begin
            m = '{default: '0};
        end else if (dif.stall_e) begin
            if (m.valid && dif.wb_we && dif.wb_wa != 0) begin
                if (dif.wb_wa == m.rs) m.a = dif.wb_wd;
                if (dif.wb_wa == m.rt) m.b = dif.wb_wd;
            end
        end else if (model_hazard()) begin
            m = '{default: '0};
            if (m_bub < BUB_MAX) m_bub++;
        end else begin
            m.valid = dif.id_valid;
            m.rs    = dif.id_rs;
            m.rt    = dif.id_rt;
            m.rd    = dif.id_rd;
            m.a     = (dif.id_rs == 0) ? '0 : dif.rf_rd1;
            m.b     = (dif.id_rt == 0) ? '0 : dif.rf_rd2;
            m.imm   = dif.id_imm;
            m.ctrl  = dif.id_valid ? dif.id_ctrl : '0;
        end
    end

    // Compare every falling edge once the model is initialised.
    always @(negedge clk) begin
        if (started) begin
            checks++;
            if (dif.ex_valid !== m.valid || dif.ex_rs !== m.rs || dif.ex_rt !== m.rt
                || dif.ex_rd !== m.rd || dif.ex_a !== m.a || dif.ex_b !== m.b
                || dif.ex_imm !== m.imm || dif.ex_ctrl !== m.ctrl
                || dif.bubbles !== PCW'(m_bub) || dif.stall_d !== model_hazard()) begin
                errors++;
                $display("[TB] FAIL model_cmp t=%0t actual v=%0b rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h ctrl=%h bub=%0d sd=%0b required v=%0b rs=%0d rt=%0d rd=%0d a=%h b=%h imm=%h ctrl=%h bub=%0d sd=%0b",
                         $time, dif.ex_valid, dif.ex_rs, dif.ex_rt, dif.ex_rd, dif.ex_a, dif.ex_b,
                         dif.ex_imm, dif.ex_ctrl, dif.bubbles, dif.stall_d,
                         m.valid, m.rs, m.rt, m.rd, m.a, m.b, m.imm, m.ctrl, m_bub, model_hazard());
            end
        end
    end

    task checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task applyStimulus(input bit v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [RW-1:0] rd, input logic [DWL-1:0] r1,
                       input logic [DWL-1:0] r2, input logic [DWL-1:0] imm,
                       input logic [CWL-1:0] ctrl);
        dif.id_valid = v;
        dif.id_rs    = rs;
        dif.id_rt    = rt;
        dif.id_rd    = rd;
        dif.rf_rd1   = r1;
        dif.rf_rd2   = r2;
        dif.id_imm   = imm;
        dif.id_ctrl  = ctrl;
    endtask

    task step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        dif.stall_e = 1'b0;
        dif.flush_e = 1'b0;
        dif.wb_we   = 1'b0;
        dif.wb_wa   = '0;
        dif.wb_wd   = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        started = 1'b1;
        checkOutput("reset_valid", 64'(dif.ex_valid), 0);
        checkOutput("reset_bubbles", 64'(dif.bubbles), 0);
        checkOutput("reset_a", 64'(dif.ex_a), 0);
        rst = 1'b0;

        // Plain capture, register 0 forces operand B to zero
        applyStimulus(1, 3, 0, 4, 32'h1234, 32'hFFFF_FFFF, 32'h10, 16'h0002);
        step();
        checkOutput("capture_a", 64'(dif.ex_a), 64'h1234);
        checkOutput("capture_b", 64'(dif.ex_b), 0);
        checkOutput("capture_valid", 64'(dif.ex_valid), 1);

        // Invalid instruction: control captured as zero, rs=0 forces A to zero
        applyStimulus(0, 0, 9, 1, 32'hAAAA, 32'h5555, 32'h7, 16'hFFFF);
        step();
        checkOutput("invalid_ctrl", 64'(dif.ex_ctrl), 0);
        checkOutput("invalid_a", 64'(dif.ex_a), 0);
        checkOutput("invalid_b", 64'(dif.ex_b), 64'h5555);

        // Load-use on rs
        applyStimulus(1, 1, 5, 5, 32'h11, 32'h22, 0, 16'h0001);
        step();
        applyStimulus(1, 5, 2, 6, 32'h33, 32'h44, 0, 16'h0000);
        #1;
        checkOutput("loaduse_stalld", 64'(dif.stall_d), 1);
        step();
        checkOutput("loaduse_valid", 64'(dif.ex_valid), 0);
        checkOutput("loaduse_bubbles", 64'(dif.bubbles), 1);
        step();

        // Load-use on rt while STALLE: hold, no bubble
        applyStimulus(1, 1, 5, 5, 32'h11, 32'h22, 0, 16'h0001);
        step();
        applyStimulus(1, 3, 5, 6, 32'h33, 32'h44, 0, 16'h0000);
        #1;
        checkOutput("hazard_rt_stalld", 64'(dif.stall_d), 1);
        dif.stall_e = 1'b1;
        step();
        checkOutput("stall_hold_valid", 64'(dif.ex_valid), 1);
        checkOutput("stall_hold_bubbles", 64'(dif.bubbles), 1);
        dif.stall_e = 1'b0;
        step();
        checkOutput("bubble2_bubbles", 64'(dif.bubbles), 2);

        // Writeback refresh while stalled
        applyStimulus(1, 7, 7, 8, 32'h11, 32'h22, 0, 16'h0000);
        step();
        dif.stall_e = 1'b1;
        dif.wb_we   = 1'b1;
        dif.wb_wa   = 5'd7;
        dif.wb_wd   = 32'hCAFE;
        step();
        checkOutput("refresh_a", 64'(dif.ex_a), 64'hCAFE);
        checkOutput("refresh_b", 64'(dif.ex_b), 64'hCAFE);
        dif.wb_wa = 5'd0;
        dif.wb_wd = 32'hBEEF;
        step();
        checkOutput("refresh_r0_a", 64'(dif.ex_a), 64'hCAFE);
        dif.stall_e = 1'b0;
        dif.wb_we   = 1'b0;
        step();

        // Flush beats stall and hides the hazard
        applyStimulus(1, 1, 5, 5, 32'h11, 32'h22, 0, 16'h0001);
        step();
        applyStimulus(1, 5, 0, 6, 32'h33, 32'h44, 0, 16'h0001);
        dif.flush_e = 1'b1;
        dif.stall_e = 1'b1;
        #1;
        checkOutput("flush_stalld", 64'(dif.stall_d), 0);
        step();
        checkOutput("flush_valid", 64'(dif.ex_valid), 0);
        checkOutput("flush_ctrl", 64'(dif.ex_ctrl), 0);
        checkOutput("flush_bubbles", 64'(dif.bubbles), 2);
        dif.flush_e = 1'b0;
        dif.stall_e = 1'b0;

        // Saturation: 18 more bubbles starting from 2
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1, 1, 5, 5, 32'h11, 32'h22, 0, 16'h0001);
            step();
            applyStimulus(1, 5, 1, 6, 32'h33, 32'h44, 0, 16'h0000);
            step();
        end
        checkOutput("saturate_bubbles", 64'(dif.bubbles), 64'(BUB_MAX));

        // Asynchronous reset between edges
        applyStimulus(1, 2, 3, 4, 32'h99, 32'h88, 32'h1, 16'h0004);
        step();
        #1;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 64'(dif.ex_valid), 0);
        checkOutput("async_rst_bubbles", 64'(dif.bubbles), 0);
        checkOutput("async_rst_a", 64'(dif.ex_a), 0);
        step();
        rst = 1'b0;
        applyStimulus(1, 2, 3, 4, 32'h99, 32'h88, 32'h1, 16'h0004);
        step();
        checkOutput("post_rst_b", 64'(dif.ex_b), 64'h88);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
